// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Three-way (debug / data / fetch) arbiter onto one single-port
//               RAM, with fetch anti-starvation and an exclusive debug lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW     = 12,
    parameter int STARVE = 4
) (
    input  logic          CPU_CLK,
    input  logic          CPU_RST,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic          IGnt,
    output logic          IValid,
    output logic [31:0]   IRdata,
    input  logic          DReq,
    input  logic [AW-1:0] DAddr,
    input  logic [3:0]    DWe,
    input  logic [31:0]   DWdata,
    output logic          DGnt,
    output logic          DValid,
    output logic [31:0]   DRdata,
    input  logic          DbgReq,
    input  logic [AW-1:0] DbgAddr,
    input  logic [3:0]    DbgWe,
    input  logic [31:0]   DbgWdata,
    input  logic          DbgLock,
    output logic          DbgGnt,
    output logic          DbgValid,
    output logic [31:0]   DbgRdata,
    output logic          RamEn,
    output logic [AW-1:0] RamAddr,
    output logic [3:0]    RamWe,
    output logic [31:0]   RamWdata,
    input  logic [31:0]   RamRdata,
    output logic          StallF,
    output logic          StallM,
    output logic          Locked
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_LOCK   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_DBG  = 2'd3
    } owner_t;

    localparam logic [2:0] C_STARVE_MAX = 3'(STARVE);

    state_t     r_state, w_state_nxt;
    owner_t     r_owner, w_owner_nxt;
    logic [2:0] r_starve, w_starve_nxt;
    logic       w_promote;

    assign w_promote = (r_starve == C_STARVE_MAX);

    // Grants are held at zero during reset so every output is quiet.
    always_comb begin
        IGnt   = 1'b0;
        DGnt   = 1'b0;
        DbgGnt = 1'b0;
        if (CPU_RST) begin
            if (r_state == ST_LOCK) begin
                DbgGnt = DbgReq;
            end else if (DbgReq) begin
                DbgGnt = 1'b1;
            end else if (w_promote && IReq) begin
                IGnt = 1'b1;
            end else if (DReq) begin
                DGnt = 1'b1;
            end else if (IReq) begin
                IGnt = 1'b1;
            end
        end
    end

    always_comb begin
        RamEn       = 1'b0;
        RamAddr     = '0;
        RamWe       = 4'b0000;
        RamWdata    = '0;
        w_owner_nxt = OWN_NONE;
        if (DbgGnt) begin
            RamEn    = 1'b1;
            RamAddr  = DbgAddr;
            RamWe    = DbgWe;
            RamWdata = DbgWdata;
            if (DbgWe == 4'b0000) w_owner_nxt = OWN_DBG;
        end else if (DGnt) begin
            RamEn    = 1'b1;
            RamAddr  = DAddr;
            RamWe    = DWe;
            RamWdata = DWdata;
            if (DWe == 4'b0000) w_owner_nxt = OWN_D;
        end else if (IGnt) begin
            RamEn    = 1'b1;
            RamAddr  = IAddr;
            w_owner_nxt = OWN_I;
        end
    end

    // The cycle that releases the lock is still arbitrated as locked.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        if (r_state == ST_NORMAL) begin
            if (DbgGnt && DbgLock) w_state_nxt = ST_LOCK;
            if (IGnt || !IReq) begin
                w_starve_nxt = 3'd0;
            end else if (r_starve < C_STARVE_MAX) begin
                w_starve_nxt = r_starve + 3'd1;
            end
        end else begin
            if (!DbgLock) w_state_nxt = ST_NORMAL;
        end
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
        if (!CPU_RST) begin
            r_state  <= ST_NORMAL;
            r_owner  <= OWN_NONE;
            r_starve <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    assign IValid   = (r_owner == OWN_I);
    assign DValid   = (r_owner == OWN_D);
    assign DbgValid = (r_owner == OWN_DBG);
    assign IRdata   = IValid   ? RamRdata : 32'd0;
    assign DRdata   = DValid   ? RamRdata : 32'd0;
    assign DbgRdata = DbgValid ? RamRdata : 32'd0;

    assign StallF = IReq & ~IGnt & CPU_RST;
    assign StallM = DReq & ~DGnt & CPU_RST;
    assign Locked = (r_state == ST_LOCK);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 12;

    logic          CPU_CLK = 1'b0;
    logic          CPU_RST;
    logic          IReq, DReq, DbgReq, DbgLock;
    logic [AW-1:0] IAddr, DAddr, DbgAddr;
    logic [3:0]    DWe, DbgWe;
    logic [31:0]   DWdata, DbgWdata;
    logic          IGnt, IValid, DGnt, DValid, DbgGnt, DbgValid;
    logic [31:0]   IRdata, DRdata, DbgRdata;
    logic          RamEn;
    logic [AW-1:0] RamAddr;
    logic [3:0]    RamWe;
    logic [31:0]   RamWdata;
    logic [31:0]   RamRdata = 32'd0;
    logic          StallF, StallM, Locked;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:255];

    always #5 CPU_CLK = ~CPU_CLK;

    mem_port_arbiter #(.AW(AW), .STARVE(4)) dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IRdata(IRdata),
        .DReq(DReq), .DAddr(DAddr), .DWe(DWe), .DWdata(DWdata),
        .DGnt(DGnt), .DValid(DValid), .DRdata(DRdata),
        .DbgReq(DbgReq), .DbgAddr(DbgAddr), .DbgWe(DbgWe), .DbgWdata(DbgWdata),
        .DbgLock(DbgLock), .DbgGnt(DbgGnt), .DbgValid(DbgValid), .DbgRdata(DbgRdata),
        .RamEn(RamEn), .RamAddr(RamAddr), .RamWe(RamWe), .RamWdata(RamWdata),
        .RamRdata(RamRdata), .StallF(StallF), .StallM(StallM), .Locked(Locked)
    );

    // Single-port RAM: word at address a initialised to 0xA500_0000 + a.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i);
    end

    always @(posedge CPU_CLK) begin
        if (RamEn) begin
            if (RamWe == 4'b0000) begin
                RamRdata <= mem[RamAddr[7:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (RamWe[b]) mem[RamAddr[7:0]][8*b +: 8] <= RamWdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CPU_CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        CPU_RST = 1'b0;
        IReq = 0; DReq = 0; DbgReq = 0; DbgLock = 0;
        IAddr = '0; DAddr = '0; DbgAddr = '0;
        DWe = 4'b0000; DbgWe = 4'b0000; DWdata = '0; DbgWdata = '0;
        repeat (2) step();

        // Reset: all outputs quiet even with requests pending
        IReq = 1; DReq = 1; DbgReq = 1; IAddr = 12'h020; DAddr = 12'h010; DbgAddr = 12'h040;
        sample();
        chk("rst_IGnt", 32'(IGnt), 0);       chk("rst_DGnt", 32'(DGnt), 0);
        chk("rst_DbgGnt", 32'(DbgGnt), 0);   chk("rst_RamEn", 32'(RamEn), 0);
        chk("rst_RamAddr", 32'(RamAddr), 0); chk("rst_StallF", 32'(StallF), 0);
        chk("rst_StallM", 32'(StallM), 0);   chk("rst_Locked", 32'(Locked), 0);
        chk("rst_IValid", 32'(IValid), 0);   chk("rst_DValid", 32'(DValid), 0);
        chk("rst_DbgValid", 32'(DbgValid), 0);
        step();

        // D beats I; D read data returns one cycle later
        CPU_RST = 1; DbgReq = 0;
        sample();
        chk("pri_DGnt", 32'(DGnt), 1);    chk("pri_IGnt", 32'(IGnt), 0);
        chk("pri_StallF", 32'(StallF), 1); chk("pri_StallM", 32'(StallM), 0);
        chk("pri_RamAddr", 32'(RamAddr), 32'h010);
        step();
        DReq = 0;
        sample();
        chk("pri_DValid", 32'(DValid), 1); chk("pri_DRdata", DRdata, 32'hA500_0010);
        chk("pri_IValid", 32'(IValid), 0); chk("pri_IRdata", IRdata, 0);
        chk("pri_IGnt2", 32'(IGnt), 1);    chk("pri_RamAddr2", 32'(RamAddr), 32'h020);
        step();
        IReq = 0;
        sample();
        chk("pri_IValid2", 32'(IValid), 1); chk("pri_IRdata2", IRdata, 32'hA500_0020);
        chk("pri_DValid2", 32'(DValid), 0); chk("idle_RamEn", 32'(RamEn), 0);
        chk("idle_RamAddr", 32'(RamAddr), 0);
        step();

        // Starvation: D wins 4 cycles, I promoted in cycle 5, counter cleared in 6
        IReq = 1; IAddr = 12'h021; DReq = 1; DAddr = 12'h011;
        for (int c = 1; c <= 6; c++) begin
            sample();
            chk($sformatf("stv%0d_IGnt", c), 32'(IGnt), (c == 5) ? 1 : 0);
            chk($sformatf("stv%0d_DGnt", c), 32'(DGnt), (c == 5) ? 0 : 1);
            if (c >= 2 && c <= 5)
                chk($sformatf("stv%0d_DRdata", c), DRdata, 32'hA500_0011);
            if (c == 6)
                chk("stv6_IRdata", IRdata, 32'hA500_0021);
            step();
        end
        IReq = 0; DReq = 0;
        step();

        // Masked write: no Valid afterwards; readback shows merged bytes
        DReq = 1; DAddr = 12'h030; DWe = 4'b0011; DWdata = 32'hAABB_CCDD;
        sample();
        chk("wr_DGnt", 32'(DGnt), 1);  chk("wr_RamEn", 32'(RamEn), 1);
        chk("wr_RamWe", 32'(RamWe), 32'h3); chk("wr_RamWdata", RamWdata, 32'hAABB_CCDD);
        step();
        DReq = 0; DWe = 4'b0000;
        sample();
        chk("wr_DValid", 32'(DValid), 0);
        step();
        DReq = 1;
        step();
        DReq = 0;
        sample();
        chk("wr_readback", DRdata, 32'hA500_CCDD);
        step();

        // Debug lock
        DbgReq = 1; DbgLock = 1; DbgAddr = 12'h040; IReq = 1; DReq = 1; IAddr = 12'h022; DAddr = 12'h012;
        sample();
        chk("lk1_DbgGnt", 32'(DbgGnt), 1); chk("lk1_DGnt", 32'(DGnt), 0);
        chk("lk1_IGnt", 32'(IGnt), 0);     chk("lk1_RamAddr", 32'(RamAddr), 32'h040);
        step();
        DbgReq = 0;
        for (int c = 2; c <= 5; c++) begin
            if (c == 5) DbgLock = 0;
            sample();
            chk($sformatf("lk%0d_Locked", c), 32'(Locked), 1);
            chk($sformatf("lk%0d_IGnt", c), 32'(IGnt), 0);
            chk($sformatf("lk%0d_DGnt", c), 32'(DGnt), 0);
            if (c == 2) chk("lk2_DbgRdata", DbgRdata, 32'hA500_0040);
            step();
        end
        sample();
        chk("lk6_Locked", 32'(Locked), 0); chk("lk6_DGnt", 32'(DGnt), 1);
        chk("lk6_RamAddr", 32'(RamAddr), 32'h012);
        step();
        IReq = 0; DReq = 0;
        step();

        // DbgLock without DbgReq does not lock
        DbgLock = 1; IReq = 1; IAddr = 12'h023;
        sample();
        chk("nolk_IGnt", 32'(IGnt), 1);
        step();
        IReq = 0; DbgLock = 0;
        sample();
        chk("nolk_Locked", 32'(Locked), 0); chk("nolk_IRdata", IRdata, 32'hA500_0023);
        step();

        // Alternating back-to-back I/D reads
        for (int k = 0; k <= 6; k++) begin
            IReq = 0; DReq = 0;
            if (k < 6) begin
                if (k % 2 == 0) begin IReq = 1; IAddr = 12'h050 + 12'(k); end
                else            begin DReq = 1; DAddr = 12'h060 + 12'(k); end
            end
            sample();
            if (k < 6) begin
                chk($sformatf("alt%0d_IGnt", k), 32'(IGnt), (k % 2 == 0) ? 1 : 0);
                chk($sformatf("alt%0d_DGnt", k), 32'(DGnt), (k % 2 == 0) ? 0 : 1);
            end
            if (k > 0) begin
                if ((k - 1) % 2 == 0) begin
                    chk($sformatf("alt%0d_IRdata", k), IRdata, 32'hA500_0050 + 32'(k - 1));
                    chk($sformatf("alt%0d_DValid", k), 32'(DValid), 0);
                    chk($sformatf("alt%0d_DRdata", k), DRdata, 0);
                end else begin
                    chk($sformatf("alt%0d_DRdata", k), DRdata, 32'hA500_0060 + 32'(k - 1));
                    chk($sformatf("alt%0d_IValid", k), 32'(IValid), 0);
                    chk($sformatf("alt%0d_IRdata", k), IRdata, 0);
                end
            end
            step();
        end

        // Reset pulse right after a read grant
        IReq = 1; IAddr = 12'h070;
        sample();
        chk("rp_IGnt", 32'(IGnt), 1);
        step();
        CPU_RST = 0; DReq = 1;
        sample();
        chk("rp_IValid", 32'(IValid), 0); chk("rp_DValid", 32'(DValid), 0);
        chk("rp_IRdata", IRdata, 0);      chk("rp_IGnt2", 32'(IGnt), 0);
        chk("rp_DGnt", 32'(DGnt), 0);     chk("rp_RamEn", 32'(RamEn), 0);
        chk("rp_StallF", 32'(StallF), 0); chk("rp_StallM", 32'(StallM), 0);
        step();
        CPU_RST = 1; DReq = 0; IAddr = 12'h071;
        sample();
        chk("rp_rel_IGnt", 32'(IGnt), 1); chk("rp_rel_IValid", 32'(IValid), 0);
        step();
        IReq = 0;
        sample();
        chk("rp_rel_IRdata", IRdata, 32'hA500_0071);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
